// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared types and helpers for the BHT branch predictor
// Contents: bht_ctr_t 2-bit counter type and its constants, bht_state_t
// controller states, ctr_next() saturating counter update.
package bpred_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_SNT = 2'b00;
    localparam bht_ctr_t CTR_WNT = 2'b01;
    localparam bht_ctr_t CTR_WT  = 2'b10;
    localparam bht_ctr_t CTR_ST  = 2'b11;

    typedef enum logic {
        BHT_INIT = 1'b0,
        BHT_RUN  = 1'b1
    } bht_state_t;

    function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : bht_ctr_t'(ctr + 2'd1);
        end
        return (ctr == CTR_SNT) ? CTR_SNT : bht_ctr_t'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/bht_ctr_table.sv
// rtl/bht_ctr_table.sv - 2-bit counter register array, one async read, one write
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata combinational read.
// No reset: contents are defined by the parent's initialisation sweep.
module bht_ctr_table
    import bpred_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_BITS-1:0] waddr,
    input  bht_ctr_t            wdata,
    input  logic [IDX_BITS-1:0] raddr,
    output bht_ctr_t            rdata
);

    bht_ctr_t mem [2**IDX_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bpred_bht_ctrl.sv
// rtl/bpred_bht_ctrl.sv - 2-bit saturating-counter branch history table controller
// Ports: clk, reset (async, active-high), flush_tbl, ready;
//   fetch lookup: cur_pc, cur_is_branch, cur_target -> pred_pc, pred_taken;
//   execute update: upd_valid, upd_pc, upd_taken, upd_mispred; miss_cnt.
// Build option: BPRED_BHT_BYPASS_EN forwards a same-cycle same-index update
// into the lookup; otherwise the lookup reads the registered table.
module bpred_bht_ctrl
    import bpred_pkg::*;
#(
    parameter int       IDX_BITS = 6,
    parameter bht_ctr_t INIT_CTR = CTR_WNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_tbl,
    output logic        ready,
    input  logic [31:0] cur_pc,
    input  logic        cur_is_branch,
    input  logic [31:0] cur_target,
    output logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_mispred,
    output logic [31:0] miss_cnt
);

    bht_state_t          state;
    logic [IDX_BITS-1:0] init_idx;
    logic                ready_q;
    logic [31:0]         miss_q;

    logic [IDX_BITS-1:0] lk_idx;
    logic [IDX_BITS-1:0] up_idx;
    bht_ctr_t            lk_ctr_raw;
    bht_ctr_t            lk_ctr;
    bht_ctr_t            up_ctr_old;
    bht_ctr_t            up_ctr_new;
    logic                upd_fire;
    logic                tbl_we;
    logic [IDX_BITS-1:0] tbl_waddr;
    bht_ctr_t            tbl_wdata;

    // PC alignment bits and bits above the index never affect the table.
    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    assign lk_idx = cur_pc[IDX_BITS+1:2];
    assign up_idx = upd_pc[IDX_BITS+1:2];

    // A flush in the same cycle wins over an update.
    assign upd_fire   = (state == BHT_RUN) && upd_valid && !flush_tbl;
    assign up_ctr_new = ctr_next(up_ctr_old, upd_taken);

    // The sweep pauses on a flush cycle; the next cycle starts again at 0.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = up_idx;
        tbl_wdata = up_ctr_new;
        if (state == BHT_INIT) begin
            tbl_we    = !flush_tbl;
            tbl_waddr = init_idx;
            tbl_wdata = INIT_CTR;
        end else if (upd_fire) begin
            tbl_we = 1'b1;
        end
    end

    // Two identical copies written together, so lookup and update each get
    // their own single read port.
    bht_ctr_table #(.IDX_BITS(IDX_BITS)) u_tbl_lookup (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (lk_idx),
        .rdata (lk_ctr_raw)
    );

    bht_ctr_table #(.IDX_BITS(IDX_BITS)) u_tbl_update (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (up_idx),
        .rdata (up_ctr_old)
    );

`ifdef BPRED_BHT_BYPASS_EN
    assign lk_ctr = (upd_fire && (up_idx == lk_idx)) ? up_ctr_new : lk_ctr_raw;
`else
    assign lk_ctr = lk_ctr_raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BHT_INIT;
            init_idx <= '0;
            ready_q  <= 1'b0;
            miss_q   <= '0;
        end else begin
            case (state)
                BHT_INIT: begin
                    if (flush_tbl) begin
                        init_idx <= '0;
                    end else if (init_idx == {IDX_BITS{1'b1}}) begin
                        state    <= BHT_RUN;
                        ready_q  <= 1'b1;
                        init_idx <= '0;
                    end else begin
                        init_idx <= init_idx + 1'b1;
                    end
                end
                BHT_RUN: begin
                    if (flush_tbl) begin
                        state    <= BHT_INIT;
                        ready_q  <= 1'b0;
                        init_idx <= '0;
                    end else if (upd_valid && upd_mispred && (miss_q != 32'hFFFF_FFFF)) begin
                        miss_q <= miss_q + 32'd1;
                    end
                end
                default: begin
                    state    <= BHT_INIT;
                    ready_q  <= 1'b0;
                    init_idx <= '0;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign miss_cnt   = miss_q;
    assign pred_taken = ready_q & cur_is_branch & lk_ctr[1];
    assign pred_pc    = pred_taken ? cur_target : (cur_pc + 32'd4);

endmodule

// File: tb/tb_bpred_bht_ctrl.sv
// tb/tb_bpred_bht_ctrl.sv - self-checking bench for bpred_bht_ctrl
module tb_bpred_bht_ctrl;

`ifdef BPRED_BHT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_tbl;
    logic        ready;
    logic [31:0] cur_pc;
    logic        cur_is_branch;
    logic [31:0] cur_target;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispred;
    logic [31:0] miss_cnt;

    always #5 clk = ~clk;

    bpred_bht_ctrl #(.IDX_BITS(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_tbl     (flush_tbl),
        .ready         (ready),
        .cur_pc        (cur_pc),
        .cur_is_branch (cur_is_branch),
        .cur_target    (cur_target),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_mispred   (upd_mispred),
        .miss_cnt      (miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer counters clamped to 0..3.
    int     ctr [64];
    bit     m_run;
    int     m_idx;
    longint m_miss;

    typedef struct {
        logic        uv;
        logic [31:0] up;
        logic        ut;
        logic        um;
        logic [31:0] cp;
        logic        cb;
        logic [31:0] ct;
        logic        et;
        logic [31:0] epc;
        logic [31:0] emiss;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    task automatic idle();
        flush_tbl   = 1'b0;
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
        upd_pc      = 32'h0;
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_idx  = 0;
        m_miss = 0;
    endtask

    // Advance the model by the current inputs, then one clock.
    task automatic cyc();
        if (!m_run) begin
            if (flush_tbl) m_idx = 0;
            else begin
                ctr[m_idx] = 1;
                if (m_idx == 63) m_run = 1'b1;
                else m_idx++;
            end
        end else if (flush_tbl) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (upd_valid) begin
            int i;
            i = idx_of(upd_pc);
            if (upd_taken) ctr[i] = (ctr[i] == 3) ? 3 : ctr[i] + 1;
            else           ctr[i] = (ctr[i] == 0) ? 0 : ctr[i] - 1;
            if (upd_mispred && m_miss < 64'hFFFF_FFFF) m_miss++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        int  c;
        bit  et;
        logic [31:0] epc;
        c = ctr[idx_of(cur_pc)];
        if (BYP && m_run && upd_valid && !flush_tbl && idx_of(upd_pc) == idx_of(cur_pc))
            c = upd_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        et  = m_run && cur_is_branch && (c >= 2);
        epc = et ? cur_target : cur_pc + 32'd4;
        chk({name, "_ready"}, {31'd0, ready}, {31'd0, m_run});
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
        chk({name, "_pc"}, pred_pc, epc);
        chk({name, "_miss"}, miss_cnt, m_miss[31:0]);
    endtask

    task automatic wait_ready(input string name, input int exp);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        foreach (ctr[i]) ctr[i] = 0;
        idle();
        reset         = 1'b0;
        cur_pc        = 32'h100;
        cur_is_branch = 1'b1;
        cur_target    = 32'h400;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pc", pred_pc, 32'h104);
        chk("rst_miss", miss_cnt, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        wait_ready("init_sweep_len", 64);
        cur_pc = 32'h100; cur_is_branch = 1'b1; cur_target = 32'h400;
        #1;
        chk("run_init_taken", {31'd0, pred_taken}, 32'd0);
        chk("run_init_pc", pred_pc, 32'h104);

        // Counter at index 0 (pc 0x100) starts weakly not-taken.
        vecs[0]  = '{1'b1, 32'h100,   1'b1, 1'b1, 32'h104,       1'b1, 32'h500, 1'b0, 32'h108, 32'd0};
        vecs[1]  = '{1'b1, 32'h100,   1'b1, 1'b0, 32'h104,       1'b1, 32'h500, 1'b0, 32'h108, 32'd1};
        vecs[2]  = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h100,       1'b1, 32'h400, 1'b1, 32'h400, 32'd1};
        vecs[3]  = '{1'b1, 32'h100,   1'b1, 1'b0, 32'h108,       1'b0, 32'h0,   1'b0, 32'h10C, 32'd1};
        vecs[4]  = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h100,       1'b1, 32'h400, 1'b1, 32'h400, 32'd1};
        vecs[5]  = '{1'b1, 32'h100,   1'b0, 1'b0, 32'h104,       1'b1, 32'h500, 1'b0, 32'h108, 32'd1};
        vecs[6]  = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h100,       1'b1, 32'h400, 1'b1, 32'h400, 32'd1};
        vecs[7]  = '{1'b1, 32'h100,   1'b0, 1'b0, 32'h104,       1'b1, 32'h500, 1'b0, 32'h108, 32'd1};
        vecs[8]  = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h100,       1'b1, 32'h400, 1'b0, 32'h104, 32'd1};
        vecs[9]  = '{1'b1, 32'h100,   1'b0, 1'b0, 32'h104,       1'b1, 32'h500, 1'b0, 32'h108, 32'd1};
        vecs[10] = '{1'b1, 32'h100,   1'b0, 1'b0, 32'h104,       1'b1, 32'h500, 1'b0, 32'h108, 32'd1};
        vecs[11] = '{1'b1, 32'h10103, 1'b1, 1'b0, 32'h104,       1'b1, 32'h500, 1'b0, 32'h108, 32'd1};
        vecs[12] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h100,       1'b1, 32'h400, 1'b0, 32'h104, 32'd1};
        vecs[13] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h40,  1'b0, 32'h0,   32'd1};

        for (int v = 0; v < 14; v++) begin
            upd_valid     = vecs[v].uv;
            upd_pc        = vecs[v].up;
            upd_taken     = vecs[v].ut;
            upd_mispred   = vecs[v].um;
            cur_pc        = vecs[v].cp;
            cur_is_branch = vecs[v].cb;
            cur_target    = vecs[v].ct;
            #1;
            chk($sformatf("vec%0d_taken", v), {31'd0, pred_taken}, {31'd0, vecs[v].et});
            chk($sformatf("vec%0d_pc", v), pred_pc, vecs[v].epc);
            chk($sformatf("vec%0d_miss", v), miss_cnt, vecs[v].emiss);
            cyc();
        end
        idle();

        // Same-index update and lookup, counter 01, taken.
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
        cur_pc = 32'h100; cur_is_branch = 1'b1; cur_target = 32'h400;
        #1;
        chk("same_cycle_taken", {31'd0, pred_taken}, {31'd0, BYP});
        cyc();
        idle();
        #1;
        chk("next_cycle_taken", {31'd0, pred_taken}, 32'd1);

        // Flush with a concurrent mispredicted update: update dropped.
        flush_tbl = 1'b1; upd_valid = 1'b1; upd_mispred = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
        cyc();
        idle();
        chk("flush_miss_kept", miss_cnt, 32'd1);
        wait_ready("flush_sweep_len", 64);
        flush_tbl = 1'b1;
        cyc();
        flush_tbl = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        chk("mid_sweep_ready", {31'd0, ready}, 32'd0);
        flush_tbl = 1'b1;
        cyc();
        flush_tbl = 1'b0;
        wait_ready("restart_sweep_len", 64);
        for (int i = 0; i < 64; i++) begin
            cur_pc = 32'(i) << 2; cur_is_branch = 1'b1; cur_target = 32'h800;
            #1;
            chk($sformatf("flushed_idx%0d", i), {31'd0, pred_taken}, 32'd0);
        end
        // One taken update must lift a weakly-NT entry to weakly-T.
        upd_valid = 1'b1; upd_pc = 32'h3C; upd_taken = 1'b1;
        cyc();
        idle();
        cur_pc = 32'h3C; cur_target = 32'h900;
        #1;
        chk("flush_value_wnt", pred_pc, 32'h900);
        chk("flush_miss_after", miss_cnt, 32'd1);

        // Randomised traffic against the model.
        for (int r = 0; r < 400; r++) begin
            flush_tbl     = ($urandom_range(0, 199) == 0);
            upd_valid     = $urandom_range(0, 1);
            upd_taken     = $urandom_range(0, 1);
            upd_mispred   = $urandom_range(0, 1);
            upd_pc        = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            cur_pc        = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
            cur_is_branch = $urandom_range(0, 1);
            cur_target    = $urandom & 32'hFFFF_FFFC;
            #1;
            check_model("rand");
            cyc();
        end
        idle();
        begin
            int n;
            n = 0;
            while (ready !== 1'b1 && n < 200) begin
                cyc();
                n++;
            end
        end

        // Async reset in RUN: takes effect without a clock edge.
        upd_valid = 1'b1; upd_mispred = 1'b1; upd_pc = 32'h20;
        cyc();
        idle();
        cur_pc = 32'h20; cur_is_branch = 1'b1; cur_target = 32'h444;
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_run_ready", {31'd0, ready}, 32'd0);
        chk("arst_run_miss", miss_cnt, 32'd0);
        chk("arst_run_pc", pred_pc, 32'h24);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 30; k++) cyc();
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_sweep_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ready("arst_sweep_len", 64);

        for (int k = 0; k < 5; k++) begin
            upd_valid = 1'b1; upd_mispred = 1'b1; upd_taken = $urandom_range(0, 1); upd_pc = 32'h140;
            cyc();
        end
        idle();
        #1;
        chk("five_mispred", miss_cnt, 32'd5);
        check_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
